// File: rtl/paula_audio_pkg.sv
// Shared types and constants for the Paula audio I2S transmitter.
package paula_audio_pkg;

    localparam int unsigned SLOTS_PER_FRAME = 32;
    localparam int unsigned SLOT_BITS       = 16;

    typedef logic signed [14:0] dac_sum_t;
    typedef logic        [15:0] slot_word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_t;

endpackage

// File: rtl/paula_audio_bclk_gen.sv
// Bit-clock generator: free-running half-period divider, toggles bclk at
// terminal count while enabled, and flags the edge events combinationally.
module paula_audio_bclk_gen
#(
    parameter int unsigned BCLK_DIV = 9
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_run,
    output logic o_bclk,
    output logic o_tc_c,
    output logic o_fall_c,
    output logic o_rise_c
);
    import paula_audio_pkg::*;

    localparam int unsigned CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BCLK_DIV - 1);

    if (BCLK_DIV < 1) begin : g_bad_div
        $error("BCLK_DIV must be at least 1");
    end

    logic [CNT_W-1:0] r_div_cnt;
    logic             r_bclk;
    logic             w_tc;

    assign w_tc     = (r_div_cnt == CNT_MAX);
    assign o_tc_c   = w_tc;
    assign o_fall_c = w_tc & i_run & r_bclk;
    assign o_rise_c = w_tc & i_run & ~r_bclk;
    assign o_bclk   = r_bclk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else begin
            r_div_cnt <= w_tc ? '0 : r_div_cnt + CNT_W'(1);
            if (w_tc && i_run) begin
                r_bclk <= ~r_bclk;
            end
        end
    end

endmodule

// File: rtl/paula_audio_i2s_tx.sv
// I2S transmitter for the Paula mixer sums: 32-slot frames, coherent L/R capture.
// Define PAULA_I2S_LJ_EN for left-justified format instead of standard I2S.
module paula_audio_i2s_tx
#(
    parameter int unsigned BCLK_DIV  = 9,
    parameter int unsigned SLOT_BITS = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [14:0] ldatasum,
    input  logic [14:0] rdatasum,
    output logic        i2s_bclk,
    output logic        i2s_lrck,
    output logic        i2s_sdata,
    output logic        sample_strobe
);
    import paula_audio_pkg::*;

    localparam int unsigned SLOT_W  = $clog2(SLOTS_PER_FRAME);
    localparam int unsigned FRAME_W = 2 * paula_audio_pkg::SLOT_BITS;

    if (SLOT_BITS != paula_audio_pkg::SLOT_BITS) begin : g_bad_slot_bits
        $error("SLOT_BITS must be 16");
    end

    tx_state_t          r_state;
    tx_state_t          w_state_next;
    logic               w_tc;
    logic               w_fall;
    logic               w_rise;
    logic               w_bclk;
    logic               w_unused_rise;
    logic               w_capture;
    logic               w_lrck_next;
    logic [SLOT_W-1:0]  r_slot;
    logic [SLOT_W-1:0]  w_slot_next;
    logic [FRAME_W-1:0] r_shift;
    logic               r_lrck;
    logic               r_sdata;
    logic               r_strobe;
    slot_word_t         w_l16;
    slot_word_t         w_r16;
`ifndef PAULA_I2S_LJ_EN
    logic               r_rlsb;
`endif

    paula_audio_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_run    (r_state == ST_RUN),
        .o_bclk   (w_bclk),
        .o_tc_c   (w_tc),
        .o_fall_c (w_fall),
        .o_rise_c (w_rise)
    );

    // Rising edges carry no serializer work; all updates happen on the fall.
    assign w_unused_rise = w_rise;

    // One idle half-period with bclk low, then run until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_tc) w_state_next = ST_RUN;
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_slot_next = r_slot + SLOT_W'(1);
    assign w_capture   = (w_slot_next == '0);
    assign w_l16       = {ldatasum, 1'b0};
    assign w_r16       = {rdatasum, 1'b0};
`ifdef PAULA_I2S_LJ_EN
    assign w_lrck_next = ~w_slot_next[SLOT_W-1];
`else
    assign w_lrck_next = w_slot_next[SLOT_W-1];
`endif

    // Slot counter, capture and MSB-first serializer, all advanced on bclk fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot   <= '0;
            r_shift  <= '0;
            r_lrck   <= 1'b0;
            r_sdata  <= 1'b0;
            r_strobe <= 1'b0;
`ifndef PAULA_I2S_LJ_EN
            r_rlsb   <= 1'b0;
`endif
        end else begin
            r_strobe <= 1'b0;
            if (w_fall) begin
                r_slot <= w_slot_next;
                r_lrck <= w_lrck_next;
                if (w_capture) begin
                    r_strobe <= 1'b1;
`ifdef PAULA_I2S_LJ_EN
                    r_sdata  <= w_l16[15];
                    r_shift  <= {w_l16[14:0], w_r16, 1'b0};
`else
                    // Slot 0 still owes the previous frame's right LSB.
                    r_sdata  <= r_rlsb;
                    r_rlsb   <= w_r16[0];
                    r_shift  <= {w_l16, w_r16};
`endif
                end else begin
                    r_sdata <= r_shift[FRAME_W-1];
                    r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
                end
            end
        end
    end

    assign i2s_bclk      = w_bclk;
    assign i2s_lrck      = r_lrck;
    assign i2s_sdata     = r_sdata;
    assign sample_strobe = r_strobe;

endmodule

// File: tb/tb_paula_audio_i2s_tx.sv
// Directed bench for paula_audio_i2s_tx; expectations follow PAULA_I2S_LJ_EN.
module tb_paula_audio_i2s_tx;

    localparam int DIV = 9;
`ifdef PAULA_I2S_LJ_EN
    localparam int L_OFS = 0;
`else
    localparam int L_OFS = 1;
`endif

    logic        clk;
    logic        reset_n;
    logic [14:0] ldatasum;
    logic [14:0] rdatasum;
    logic        i2s_bclk;
    logic        i2s_lrck;
    logic        i2s_sdata;
    logic        sample_strobe;

    int n_cmp;
    int n_fail;
    int cyc;
    int stb_cnt;
    int stb_last;

    paula_audio_i2s_tx #(
        .BCLK_DIV  (DIV),
        .SLOT_BITS (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ldatasum      (ldatasum),
        .rdatasum      (rdatasum),
        .i2s_bclk      (i2s_bclk),
        .i2s_lrck      (i2s_lrck),
        .i2s_sdata     (i2s_sdata),
        .sample_strobe (sample_strobe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n clocks, sampling 1 time unit after each rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            if (sample_strobe) begin
                stb_cnt++;
                stb_last = cyc;
            end
        end
    endtask

    task automatic goto_cyc(input int k);
        if (k > cyc) step(k - cyc);
    endtask

    // Clock count after reset release at which absolute slot a begins (a >= 1).
    function automatic int edge_of(input int a);
        return DIV + 2 * DIV * a;
    endfunction

    function automatic logic exp_lrck(input int s);
`ifdef PAULA_I2S_LJ_EN
        return (s < 16) ? 1'b1 : 1'b0;
`else
        return (s < 16) ? 1'b0 : 1'b1;
`endif
    endfunction

    task automatic get_bits(input int a0, input int n, output logic [15:0] w);
        w = '0;
        for (int i = 0; i < n; i++) begin
            goto_cyc(edge_of(a0 + i));
            w = {w[14:0], i2s_sdata};
        end
    endtask

    task automatic release_reset();
        reset_n  = 1'b1;
        cyc      = 0;
        stb_cnt  = 0;
        stb_last = 0;
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] w2;
        n_cmp    = 0;
        n_fail   = 0;
        cyc      = 0;
        stb_cnt  = 0;
        stb_last = 0;
        reset_n  = 1'b0;
        ldatasum = 15'h2AAA;
        rdatasum = 15'h5555;

        repeat (3) @(posedge clk);
        #1;
        check("rst_bclk",   32'(i2s_bclk),      32'(0));
        check("rst_lrck",   32'(i2s_lrck),      32'(0));
        check("rst_sdata",  32'(i2s_sdata),     32'(0));
        check("rst_strobe", 32'(sample_strobe), 32'(0));

        release_reset();
        goto_cyc(17); check("bclk_idle_17",  32'(i2s_bclk), 32'(0));
        goto_cyc(18); check("bclk_rise_18",  32'(i2s_bclk), 32'(1));
        goto_cyc(26); check("bclk_high_26",  32'(i2s_bclk), 32'(1));
        goto_cyc(27); check("bclk_fall_27",  32'(i2s_bclk), 32'(0));
        goto_cyc(36); check("bclk_rise_36",  32'(i2s_bclk), 32'(1));

        goto_cyc(edge_of(5));  check("lrck_slot5",  32'(i2s_lrck), 32'(exp_lrck(5)));
        goto_cyc(edge_of(20)); check("lrck_slot20", 32'(i2s_lrck), 32'(exp_lrck(20)));

        goto_cyc(edge_of(32) - 1);
        check("strobe_pre",     32'(sample_strobe), 32'(0));
        check("strobe_cnt_pre", 32'(stb_cnt),       32'(0));
        goto_cyc(edge_of(32));
        check("strobe_cap1", 32'(sample_strobe), 32'(1));
`ifndef PAULA_I2S_LJ_EN
        check("slot0_first", 32'(i2s_sdata), 32'(0));
`endif
        ldatasum = 15'h4000;
        rdatasum = 15'h3FFF;

        get_bits(32 + L_OFS, 16, w);      check("frame1_left",  32'(w), 32'h5554);
        get_bits(48 + L_OFS, 16, w);      check("frame1_right", 32'(w), 32'hAAAA);

        goto_cyc(edge_of(64));
        check("strobe_cnt_2",   32'(stb_cnt),  32'(2));
        check("strobe_spacing", 32'(stb_last), 32'(edge_of(32) + 576));

        get_bits(64 + L_OFS, 8, w);
        ldatasum = 15'h0001;
        get_bits(72 + L_OFS, 8, w2);
        check("frame2_left_fs",  32'({w[7:0], w2[7:0]}), 32'h8000);
        get_bits(80 + L_OFS, 16, w);      check("frame2_right_fs", 32'(w), 32'h7FFE);
        get_bits(96 + L_OFS, 16, w);      check("frame3_left_new", 32'(w), 32'h0002);
        check("strobe_cnt_3", 32'(stb_cnt), 32'(3));

        goto_cyc(edge_of(116) + DIV + 1);
        check("pre_rst_bclk",  32'(i2s_bclk),  32'(1));
        check("pre_rst_lrck",  32'(i2s_lrck),  32'(exp_lrck(20)));
        check("pre_rst_sdata", 32'(i2s_sdata), 32'(1));
        reset_n = 1'b0;
        #1;
        check("midrst_bclk",   32'(i2s_bclk),      32'(0));
        check("midrst_lrck",   32'(i2s_lrck),      32'(0));
        check("midrst_sdata",  32'(i2s_sdata),     32'(0));
        check("midrst_strobe", 32'(sample_strobe), 32'(0));
        repeat (3) @(posedge clk);
        #1;

        release_reset();
        goto_cyc(17); check("re_bclk_idle", 32'(i2s_bclk), 32'(0));
        goto_cyc(18); check("re_bclk_rise", 32'(i2s_bclk), 32'(1));
        get_bits(1, 16, w);               check("re_frame0_zero", 32'(w), 32'h0000);
        goto_cyc(edge_of(32));
        check("re_strobe_cnt", 32'(stb_cnt), 32'(1));
`ifndef PAULA_I2S_LJ_EN
        check("re_slot0_bit", 32'(i2s_sdata), 32'(0));
`endif
        get_bits(32 + L_OFS, 16, w);      check("re_frame1_left", 32'(w), 32'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
